rw_port_arbiter: RTL
====================

# rw_port_arbiter

Arbitrates a read requester and a write requester onto one single-port synchronous memory so that a read and a write are never issued in the same cycle. Round-robin on conflict, optional bus-turnaround cycles on direction change, registered grants, a two-cycle read-return path and a saturating conflict counter. Sits between the rd/wr request sources and the shared memory macro.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TURNAROUND, 1, idle cycles inserted on read<->write direction change (0..3)
- clk  in  1  clock, all flops on posedge
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  read request, level, held until rd_gnt
- rd_addr  in  ADDR_W  read address, stable while rd_req
- rd_gnt  out  1  one-cycle pulse, read issued this cycle
- rd_data  out  DATA_W  read data, valid with rd_valid
- rd_valid  out  1  one-cycle pulse
- wr_req  in  1  write request, level, held until wr_gnt
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  one-cycle pulse, write issued this cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read access
- conflict_cnt  out  8  saturating count of arbitrations with both requests high

## Operation
- FSM states: IDLE, TURN, GRANT. All outputs registered.
- IDLE: no request -> stay. One request -> select it. Both -> select the direction opposite last_dir; increment conflict_cnt (saturate at 255).
- If has_prev=1, selected dir != last_dir and TURNAROUND>0 -> TURN, load turn counter with TURNAROUND; else -> GRANT.
- TURN: decrement counter; at 1 -> GRANT. Selection latched at IDLE exit; requests are not re-sampled (requester must hold req).
- GRANT (exactly 1 cycle): mem_en=1, mem_we=dir, mem_addr/mem_wdata from selected requester, matching gnt=1. Update last_dir=dir, has_prev=1. Next state always IDLE, so a stale req is never granted twice.
- Read return: mem_rdata captured at end of the cycle after a read GRANT; rd_valid=1 and rd_data=captured value the following cycle.
- Invariants: rd_gnt & wr_gnt never both 1; mem_en == rd_gnt | wr_gnt; mem_we == wr_gnt.
- Reset values: state IDLE, last_dir=write (read wins first conflict), has_prev=0, all gnt/mem_en/mem_we/rd_valid 0, mem_addr/mem_wdata/rd_data 0, conflict_cnt 0.
- Reset mid-operation: asynchronous clear; in-flight read return discarded (no rd_valid after reset deassertion).
- Address/data widths pass through unchanged; no arithmetic except the turn counter (2-bit) and the conflict counter.

## Timing
- Request seen at edge E (state IDLE) -> grant in cycle after E when no turnaround, else after TURNAROUND extra cycles.
- Same-direction back-to-back: one grant every 2 cycles per requester.
- Direction change: 2 + TURNAROUND cycles between grants.
- Read latency: rd_valid exactly 2 cycles after the rd_gnt cycle.
- Requester samples gnt at the edge ending the GRANT cycle and drops or updates req there.
- Request arriving during TURN or GRANT waits for next IDLE.

## Test plan
- Reset then rd_req=1, rd_addr=0x10, mem returns 0xA5 -> rd_gnt and mem_en, mem_we=0, mem_addr=0x10 one cycle after the request; rd_valid with rd_data=0xA5 2 cycles later; conflict_cnt=0.
- wr_req=1, wr_addr=0x20, wr_data=0x5A, no prior access -> wr_gnt, mem_we=1, mem_addr=0x20, mem_wdata=0x5A with no TURN cycle.
- rd_req and wr_req both high from reset, TURNAROUND=1 -> read granted first, wr_gnt 3 cycles after rd_gnt, conflict_cnt=1; gnt never overlap.
- Both held continuously for 20 cycles, TURNAROUND=0 -> grants alternate R,W,R,W every 2 cycles; conflict_cnt increments once per arbitration.
- 300 conflicting arbitrations -> conflict_cnt saturates at 255.
- rst asserted in cycle after a read GRANT -> all outputs 0 immediately, no rd_valid after release, next request granted normally with no turnaround.

Source files
------------

// File: rtl/rw_port_arbiter.sv
// rw_port_arbiter: serialises a read and a write requester onto one single-port
// synchronous memory. Round-robin on conflict, optional turnaround cycles on a
// direction change, registered grants, two-cycle read return and a saturating
// conflict counter.
module rw_port_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StTurn, StGrant} state_e;

  localparam logic [1:0] TurnLoad = 2'(TURNAROUND);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;        // selected direction, 1 = write
  logic        last_q, last_d;      // direction of the last grant, 1 = write
  logic        prev_q, prev_d;      // a grant has happened since reset
  logic [1:0]  turn_q, turn_d;
  logic [7:0]  cnt_q, cnt_d;

  logic              rd_gnt_q, wr_gnt_q, mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_pend_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              grant_d;

  // Next-state: arbitration in idle, turnaround countdown, single grant cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    prev_d  = prev_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req || wr_req) begin
          if (rd_req && wr_req) begin
            sel_d = ~last_q;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else begin
            sel_d = wr_req;
          end
          if (prev_q && (sel_d != last_q) && (TurnLoad != 2'd0)) begin
            state_d = StTurn;
            turn_d  = TurnLoad;
          end else begin
            state_d = StGrant;
          end
        end
      end
      StTurn: begin
        turn_d = turn_q - 2'd1;
        if (turn_q == 2'd1) state_d = StGrant;
      end
      StGrant: begin
        // Always back to idle so a requester that has not yet dropped its
        // request is never granted twice.
        state_d = StIdle;
        last_d  = sel_q;
        prev_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_d = (state_d == StGrant);

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;  // read wins the first conflict
      prev_q  <= 1'b0;
      turn_q  <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered memory strobes and grants, asserted for the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rd_gnt_q <= grant_d & ~sel_d;
      wr_gnt_q <= grant_d & sel_d;
      mem_en_q <= grant_d;
      mem_we_q <= grant_d & sel_d;
      if (grant_d) begin
        mem_addr_q <= sel_d ? wr_addr : rd_addr;
        if (sel_d) mem_wdata_q <= wr_data;
      end
    end
  end

  // Read return: memory data is valid the cycle after the read grant, then
  // presented one cycle later. Reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= rd_gnt_q;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= mem_rdata;
    end
  end

  assign rd_gnt       = rd_gnt_q;
  assign wr_gnt       = wr_gnt_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign conflict_cnt = cnt_q;

endmodule
